// File: rtl/pio_arb_pkg.sv
// Shared state encoding and default widths for the PIO slave arbiter.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = 2;

endpackage

// File: rtl/pio_rr_picker.sv
// Rotating-priority one-hot picker: the first set bit of req at or after ptr wins.
module pio_rr_picker
  import pio_arb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] pos;

  // Walk from the farthest position back to ptr so the nearest hit overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = {1'b0, ptr} + (IW + 1)'(i);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (req[pos[IW-1:0]]) begin
        grant = '0;
        grant[pos[IW-1:0]] = 1'b1;
        idx = pos[IW-1:0];
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/my_softcore_pio_arbiter.sv
// Round-robin arbiter sharing one PIO Avalon slave between N requesters, one transaction in flight.
// Define PIO_ARB_LOCK_EN to let a requester hold the grant across transactions via req_lock.
module my_softcore_pio_arbiter
  import pio_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_write,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  input  logic [N_REQ-1:0]    req_lock,
  output logic [N_REQ-1:0]    req_ready,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                busy,
  output logic                pio_chipselect,
  output logic                pio_write_n,
  output logic [AW-1:0]       pio_address,
  output logic [DW-1:0]       pio_writedata,
  input  logic [DW-1:0]       pio_readdata
);

  localparam int IW = $clog2(N_REQ);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    lat_id;
  logic             lat_write;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             accept;

  logic [AW-1:0] addr_arr  [N_REQ];
  logic [DW-1:0] wdata_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
  end

`ifdef PIO_ARB_LOCK_EN
  logic          lock_active;
  logic          lat_lock;
  logic [IW-1:0] lock_owner;

  // Lock state follows the last completed transaction, so only the owner can ever change it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lat_lock    <= 1'b0;
      lock_owner  <= '0;
    end else begin
      if (accept) lat_lock <= req_lock[pick_idx];
      if (state == RESP) begin
        lock_active <= lat_lock;
        lock_owner  <= lat_id;
      end
    end
  end

  assign eligible = lock_active ? (req_valid & (N_REQ'(1) << lock_owner)) : req_valid;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign eligible    = req_valid;
`endif

  pio_rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_ready = (state == IDLE) ? pick_grant : '0;
  assign accept    = (state == IDLE) && pick_any;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      lat_id         <= '0;
      lat_write      <= 1'b0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= '0;
      pio_writedata  <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= ISSUE;
            lat_id         <= pick_idx;
            lat_write      <= req_write[pick_idx];
            pio_address    <= addr_arr[pick_idx];
            pio_writedata  <= wdata_arr[pick_idx];
            pio_chipselect <= 1'b1;
            pio_write_n    <= ~req_write[pick_idx];
            rr_ptr         <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        ISSUE: begin
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          if (lat_write) begin
            state     <= RESP;
            rsp_valid <= N_REQ'(1) << lat_id;
            rsp_rdata <= '0;
          end else begin
            state <= CAPTURE;
          end
        end
        // The slave registers its read data, so it is only valid one cycle after the address.
        CAPTURE: begin
          state     <= RESP;
          rsp_rdata <= pio_readdata;
          rsp_valid <= N_REQ'(1) << lat_id;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= '0;
          rsp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
